// File: rtl/eth_rx_slot_ctrl_pkg.sv
// Shared types and width helpers for the Ethernet RX slot controller.
package eth_rx_slot_ctrl_pkg;

  localparam int unsigned ETH_LEN_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } rx_state_e;

  // Offset counter needs one extra bit so it can hold the full slot size (oversize marker).
  function automatic int unsigned off_w(input int unsigned log2_slot_bytes);
    return log2_slot_bytes + 1;
  endfunction

  function automatic int unsigned slot_w(input int unsigned log2_slots);
    return log2_slots;
  endfunction

endpackage

// File: rtl/eth_rx_slot_ctrl_if.sv
// MAC byte stream, RX RAM write port and host-side frame status of the RX slot controller.
interface eth_rx_slot_ctrl_if #(
  parameter int unsigned LOG2_SLOTS      = 2,
  parameter int unsigned LOG2_SLOT_BYTES = 11
);
  localparam int unsigned AW = LOG2_SLOTS + LOG2_SLOT_BYTES;

  logic                  rx_valid;
  logic                  rx_sof;
  logic                  rx_eof;
  logic                  rx_err;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [7:0]            mem_wdata;
  logic                  rd_avail;
  logic [LOG2_SLOTS-1:0] rd_slot;
  logic [15:0]           rd_len;
  logic                  rd_release;
  logic [LOG2_SLOTS:0]   pending;
  logic [15:0]           n_discard;
  logic                  irq_en;
  logic                  irq;

  modport master (
    output rx_valid, rx_sof, rx_eof, rx_err, rx_data, rd_release, irq_en,
    input  mem_we, mem_waddr, mem_wdata, rd_avail, rd_slot, rd_len, pending, n_discard, irq
  );

  modport slave (
    input  rx_valid, rx_sof, rx_eof, rx_err, rx_data, rd_release, irq_en,
    output mem_we, mem_waddr, mem_wdata, rd_avail, rd_slot, rd_len, pending, n_discard, irq
  );
endinterface

// File: rtl/eth_rx_slot_ctrl_ring.sv
// Slot ring bookkeeping: write/read pointers, pending count and per-slot frame lengths.
module eth_rx_slot_ctrl_ring
  import eth_rx_slot_ctrl_pkg::*;
#(
  parameter int unsigned LOG2_SLOTS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  commit_i,
  input  logic [ETH_LEN_W-1:0]  commit_len_i,
  input  logic                  release_i,
  output logic [LOG2_SLOTS-1:0] wr_ptr_o,
  output logic                  rd_avail_o,
  output logic [LOG2_SLOTS-1:0] rd_slot_o,
  output logic [ETH_LEN_W-1:0]  rd_len_o,
  output logic [LOG2_SLOTS:0]   pending_o
);
  localparam int unsigned NumSlots = 2 ** LOG2_SLOTS;

  logic [LOG2_SLOTS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG2_SLOTS:0]   pending_q, pending_d;
  logic [ETH_LEN_W-1:0]  len_q [NumSlots];
  logic [ETH_LEN_W-1:0]  len_d [NumSlots];
  logic                  rel_ok;

  assign rel_ok = release_i && (pending_q != '0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pending_d = pending_q;
    len_d     = len_q;
    if (commit_i) begin
      wr_ptr_d        = wr_ptr_q + 1'b1;
      len_d[wr_ptr_q] = commit_len_i;
    end
    if (rel_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous commit and release leave the count untouched.
    case ({commit_i, rel_ok})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
      for (int i = 0; i < NumSlots; i++) len_q[i] <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pending_q <= pending_d;
      len_q     <= len_d;
    end
  end

  assign wr_ptr_o   = wr_ptr_q;
  assign rd_avail_o = (pending_q != '0);
  assign rd_slot_o  = rd_ptr_q;
  assign rd_len_o   = rd_avail_o ? len_q[rd_ptr_q] : '0;
  assign pending_o  = pending_q;

endmodule

// File: rtl/eth_rx_slot_ctrl.sv
// Ethernet RX slot controller: frame FSM, registered RAM write port, discard counter.
module eth_rx_slot_ctrl
  import eth_rx_slot_ctrl_pkg::*;
#(
  parameter int unsigned LOG2_SLOTS      = 2,
  parameter int unsigned LOG2_SLOT_BYTES = 11
) (
  input logic               clk,
  input logic               rst,
  eth_rx_slot_ctrl_if.slave bus
);
  localparam int unsigned AW = LOG2_SLOTS + LOG2_SLOT_BYTES;
  localparam int unsigned OW = off_w(LOG2_SLOT_BYTES);
  localparam int unsigned SW = slot_w(LOG2_SLOTS);
  localparam logic [OW-1:0] OffFull  = OW'(2 ** LOG2_SLOT_BYTES);
  localparam logic [SW:0]   NumSlots = (SW + 1)'(2 ** LOG2_SLOTS);

  rx_state_e            state_q, state_d;
  logic [OW-1:0]        off_q, off_d, wr_off;
  logic [SW-1:0]        slot_q, slot_d, wr_sel, wr_slot, wr_ptr;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_waddr_q, mem_waddr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic                 commit_q, commit_d;
  logic [ETH_LEN_W-1:0] commit_len_q, commit_len_d;
  logic [ETH_LEN_W-1:0] disc_q, disc_d;
  logic [SW:0]          pending, occupied;
  logic                 rd_avail, wr_en, disc_inc, full;

  // A commit still in flight already owns wr_ptr, so new frames start one slot further on.
  assign wr_slot  = commit_q ? wr_ptr + 1'b1 : wr_ptr;
  assign occupied = pending + {{SW{1'b0}}, commit_q};
  assign full     = (occupied == NumSlots);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.rx_err && bus.rx_valid && bus.rx_sof && !bus.rx_eof) begin
          state_d = full ? StDrop : StRecv;
        end
      end
      StRecv: begin
        if (bus.rx_err || (bus.rx_valid && bus.rx_eof)) state_d = StIdle;
        else if (bus.rx_valid && !bus.rx_sof && off_q == OffFull) state_d = StDrop;
      end
      StDrop: begin
        if (bus.rx_err || (bus.rx_valid && bus.rx_eof)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en        = 1'b0;
    wr_sel       = slot_q;
    wr_off       = '0;
    slot_d       = slot_q;
    off_d        = off_q;
    commit_d     = 1'b0;
    commit_len_d = commit_len_q;
    disc_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && bus.rx_sof) begin
          if (bus.rx_err || full) begin
            disc_inc = 1'b1;
          end else begin
            wr_en        = 1'b1;
            wr_sel       = wr_slot;
            slot_d       = wr_slot;
            off_d        = OW'(1);
            commit_d     = bus.rx_eof;
            commit_len_d = ETH_LEN_W'(1);
          end
        end
      end
      StRecv: begin
        if (bus.rx_err) begin
          disc_inc = 1'b1;
        end else if (bus.rx_valid) begin
          if (bus.rx_sof) begin
            disc_inc     = 1'b1;
            wr_en        = 1'b1;
            off_d        = OW'(1);
            commit_d     = bus.rx_eof;
            commit_len_d = ETH_LEN_W'(1);
          end else if (off_q == OffFull) begin
            disc_inc = 1'b1;
          end else begin
            wr_en        = 1'b1;
            wr_off       = off_q;
            off_d        = off_q + 1'b1;
            commit_d     = bus.rx_eof;
            commit_len_d = ETH_LEN_W'(off_q) + 1'b1;
          end
        end
      end
      default: ;
    endcase
    mem_we_d    = wr_en;
    mem_waddr_d = wr_en ? {wr_sel, wr_off[LOG2_SLOT_BYTES-1:0]} : mem_waddr_q;
    mem_wdata_d = wr_en ? bus.rx_data : mem_wdata_q;
    disc_d      = (disc_inc && disc_q != '1) ? disc_q + 1'b1 : disc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q        <= '0;
      slot_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      commit_q     <= 1'b0;
      commit_len_q <= '0;
      disc_q       <= '0;
    end else begin
      off_q        <= off_d;
      slot_q       <= slot_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      commit_q     <= commit_d;
      commit_len_q <= commit_len_d;
      disc_q       <= disc_d;
    end
  end

  eth_rx_slot_ctrl_ring #(
    .LOG2_SLOTS(LOG2_SLOTS)
  ) u_ring (
    .clk_i       (clk),
    .rst_i       (rst),
    .commit_i    (commit_q),
    .commit_len_i(commit_len_q),
    .release_i   (bus.rd_release),
    .wr_ptr_o    (wr_ptr),
    .rd_avail_o  (rd_avail),
    .rd_slot_o   (bus.rd_slot),
    .rd_len_o    (bus.rd_len),
    .pending_o   (pending)
  );

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_avail  = rd_avail;
  assign bus.pending   = pending;
  assign bus.n_discard = disc_q;
  assign bus.irq       = bus.irq_en && rd_avail;

endmodule

// File: tb/tb_eth_rx_slot_ctrl.sv
// Directed plus randomized bench for eth_rx_slot_ctrl against a frame-level queue model.
module tb_eth_rx_slot_ctrl;
  localparam int LS = 2;
  localparam int LB = 11;
  localparam int NS = 4;
  localparam int SB = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_slot_ctrl_if #(.LOG2_SLOTS(LS), .LOG2_SLOT_BYTES(LB)) bus ();

  eth_rx_slot_ctrl #(
    .LOG2_SLOTS     (LS),
    .LOG2_SLOT_BYTES(LB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Captured RAM image and the image the model says it should hold.
  logic [7:0] ram     [NS*SB];
  logic [7:0] exp_ram [NS*SB];
  int wr_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_waddr] = bus.mem_wdata;
      wr_cnt++;
    end
  end

  int q_slot[$];
  int q_len[$];
  int exp_wr, exp_disc, exp_writes;
  bit open_frame;
  bit irq_en_v;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mism();
    int m = 0;
    for (int i = 0; i < NS * SB; i++) if (ram[i] !== exp_ram[i]) m++;
    return m;
  endfunction

  task automatic disc_inc();
    if (exp_disc < 65535) exp_disc++;
  endtask

  task automatic drive_idle();
    bus.rx_valid   = 1'b0;
    bus.rx_sof     = 1'b0;
    bus.rx_eof     = 1'b0;
    bus.rx_err     = 1'b0;
    bus.rx_data    = 8'h00;
    bus.rd_release = 1'b0;
  endtask

  task automatic set_irq(input bit v);
    irq_en_v   = v;
    bus.irq_en = v;
  endtask

  task automatic check_state(input string tag);
    int n = q_len.size();
    chk({tag, ".avail"}, bus.rd_avail, n > 0);
    if (n > 0) chk({tag, ".slot"}, bus.rd_slot, q_slot[0]);
    chk({tag, ".len"}, bus.rd_len, (n > 0) ? q_len[0] : 0);
    chk({tag, ".pending"}, bus.pending, n);
    chk({tag, ".discard"}, bus.n_discard, exp_disc);
    chk({tag, ".irq"}, bus.irq, irq_en_v && (n > 0));
    chk({tag, ".writes"}, wr_cnt, exp_writes);
    chk({tag, ".data"}, mism(), 0);
  endtask

  task automatic do_reset(input string tag);
    set_irq(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk({tag, ".mem_we"}, bus.mem_we, 0);
    chk({tag, ".mem_waddr"}, bus.mem_waddr, 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".rd_avail"}, bus.rd_avail, 0);
    chk({tag, ".rd_slot"}, bus.rd_slot, 0);
    chk({tag, ".rd_len"}, bus.rd_len, 0);
    chk({tag, ".pending"}, bus.pending, 0);
    chk({tag, ".n_discard"}, bus.n_discard, 0);
    chk({tag, ".irq"}, bus.irq, 0);
    @(negedge clk);
    rst = 1'b0;
    q_slot.delete();
    q_len.delete();
    exp_wr     = 0;
    exp_disc   = 0;
    open_frame = 1'b0;
  endtask

  // One frame of len bytes; err_at >= 0 aborts with rx_err after err_at bytes.
  task automatic send_frame(input int len, input int err_at, input bit ramp, input bit rel_commit,
                            input string tag);
    logic [7:0] d[$];
    logic [7:0] b;
    int nb, prev, slot, nw;
    bit full;
    full = !open_frame && (q_len.size() == NS);
    if (open_frame) begin
      disc_inc();
      open_frame = 1'b0;
    end
    slot = exp_wr;
    prev = q_len.size();
    nb   = (err_at >= 0) ? err_at : len;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      b            = ramp ? 8'(i) : 8'($urandom);
      bus.rx_valid = 1'b1;
      bus.rx_sof   = (i == 0);
      bus.rx_eof   = (err_at < 0) && (i == len - 1);
      bus.rx_data  = b;
      d.push_back(b);
    end
    if (err_at >= 0) begin
      @(negedge clk);
      drive_idle();
      bus.rx_err = 1'b1;
    end
    @(negedge clk);
    drive_idle();
    if (rel_commit) bus.rd_release = 1'b1;
    chk({tag, ".precommit"}, bus.pending, prev);
    if (full) begin
      disc_inc();
    end else begin
      nw = (nb < SB) ? nb : SB;
      for (int i = 0; i < nw; i++) exp_ram[slot*SB+i] = d[i];
      exp_writes += nw;
      if (err_at >= 0 || nb > SB) disc_inc();
      else begin
        q_slot.push_back(slot);
        q_len.push_back(len);
        exp_wr = (exp_wr + 1) % NS;
      end
    end
    if (rel_commit && prev > 0) begin
      void'(q_slot.pop_front());
      void'(q_len.pop_front());
    end
    @(negedge clk);
    bus.rd_release = 1'b0;
    check_state(tag);
  endtask

  // Starts a frame without ending it; the next frame's sof aborts it.
  task automatic send_partial(input int k);
    logic [7:0] b;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      b            = 8'($urandom);
      bus.rx_valid = 1'b1;
      bus.rx_sof   = (i == 0);
      bus.rx_data  = b;
      exp_ram[exp_wr*SB+i] = b;
    end
    exp_writes += k;
    open_frame = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic release_head(input string tag);
    @(negedge clk);
    bus.rd_release = 1'b1;
    @(negedge clk);
    bus.rd_release = 1'b0;
    if (q_len.size() > 0) begin
      void'(q_slot.pop_front());
      void'(q_len.pop_front());
    end
    check_state(tag);
  endtask

  int r, l;

  initial begin
    for (int i = 0; i < NS * SB; i++) begin
      ram[i]     = 8'h00;
      exp_ram[i] = 8'h00;
    end
    exp_writes = 0;
    drive_idle();
    set_irq(1'b0);
    do_reset("rst0");

    // 60-byte ramp frame, irq masked, then a stray non-sof byte in idle.
    set_irq(1'b0);
    send_frame(60, -1, 1'b1, 1'b0, "t1");
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    check_state("t1.stray");
    set_irq(1'b1);
    @(negedge clk);
    chk("t1.irq_on", bus.irq, 1);
    release_head("t1.rel");

    // Ring fills, fifth frame dropped, release then wrap into slot 0.
    do_reset("t2.rst");
    for (int i = 0; i < 5; i++) send_frame(64, -1, 1'b0, 1'b0, "t2.fill");
    release_head("t2.rel");
    send_frame(64, -1, 1'b0, 1'b0, "t2.wrap");

    do_reset("t3.rst");
    send_frame(80, 37, 1'b0, 1'b0, "t3.err");
    send_frame(100, -1, 1'b0, 1'b0, "t3.good");

    do_reset("t4.rst");
    send_frame(2049, -1, 1'b0, 1'b0, "t4.over");
    send_frame(2048, -1, 1'b0, 1'b0, "t4.max");
    send_frame(1, -1, 1'b0, 1'b0, "t4.one");

    do_reset("t5.rst");
    send_frame(50, -1, 1'b0, 1'b0, "t5.a");
    send_frame(70, -1, 1'b0, 1'b0, "t5.b");
    send_frame(30, -1, 1'b0, 1'b1, "t5.coincide");
    send_partial(12);
    send_frame(40, -1, 1'b0, 1'b0, "t5.restart");

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        release_head("rnd.rel");
      end else if (r == 2) begin
        set_irq(1'($urandom_range(0, 1)));
        @(negedge clk);
        check_state("rnd.irq");
      end else if (r == 3 && !open_frame && q_len.size() < NS) begin
        send_partial($urandom_range(1, 20));
      end else if (r == 4) begin
        l = $urandom_range(2, 80);
        send_frame(l, $urandom_range(1, l - 1), 1'b0, 1'b0, "rnd.err");
      end else begin
        l = $urandom_range(1, 120);
        send_frame(l, -1, 1'b0, 1'($urandom_range(0, 1)), "rnd.frame");
      end
    end

    // Reset mid-frame with frames pending and discards counted.
    if (open_frame) send_frame(10, -1, 1'b0, 1'b0, "t6.close");
    send_frame(20, 5, 1'b0, 1'b0, "t6.err");
    while (q_len.size() == NS) release_head("t6.drain");
    send_partial(30);
    do_reset("t6.rst");
    send_frame(20, -1, 1'b0, 1'b0, "t6.after");
    chk("t6.after_slot", bus.rd_slot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
